// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - iterative multiply/divide/multiply-accumulate unit for the execute stage
module ex_muldiv #(
  parameter int WIDTH      = 32,
  parameter bit EARLY_ZERO = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [1:0]           op_i,
  input  logic                 signed_i,
  input  logic [WIDTH-1:0]     opa_i,
  input  logic [WIDTH-1:0]     opb_i,
  input  logic [2*WIDTH-1:0]   hilo_i,
  input  logic                 annul_i,
  output logic                 busy_o,
  output logic [WIDTH-1:0]     hi_o,
  output logic [WIDTH-1:0]     lo_o,
  output logic                 whilo_o,
  output logic                 dbz_o
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] OP_MULT = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_MADD = 2'b10;
  localparam logic [1:0] OP_MSUB = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  // Shared working register: upper half is the partial product / remainder,
  // lower half is the multiplier being shifted out / quotient being shifted in.
  logic [2*WIDTH-1:0]   work_q, work_d;
  // Magnitude of the second operand: addend for multiply, divisor for divide.
  logic [WIDTH-1:0]     opd_q, opd_d;
  logic [1:0]           op_q, op_d;
  logic                 neg_p_q, neg_p_d;
  logic                 neg_r_q, neg_r_d;
  logic [2*WIDTH-1:0]   hilo_q, hilo_d;
  logic [2*WIDTH-1:0]   res_q, res_d;
  logic                 dbz_q, dbz_d;

  logic                 neg_a, neg_b;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic                 fast_dbz, fast_zero;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_step;
  logic [WIDTH:0]       div_shift;
  logic [WIDTH:0]       div_diff;
  logic [2*WIDTH-1:0]   div_step;
  logic [2*WIDTH-1:0]   prod_s;
  logic [WIDTH-1:0]     quot_s, rem_s;
  logic [2*WIDTH-1:0]   fix_res;

  // Operand decode: magnitudes, signs and fast-path detection on the request
  always_comb begin
    neg_a     = signed_i & opa_i[WIDTH-1];
    neg_b     = signed_i & opb_i[WIDTH-1];
    mag_a     = neg_a ? -opa_i : opa_i;
    mag_b     = neg_b ? -opb_i : opb_i;
    fast_dbz  = (op_i == OP_DIV) && (opb_i == '0);
    fast_zero = EARLY_ZERO && (op_i != OP_DIV) && ((opa_i == '0) || (opb_i == '0));
  end

  // One iteration step for shift-add multiply and restoring divide
  always_comb begin
    mul_sum   = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, opd_q} : '0);
    mul_step  = {mul_sum, work_q[WIDTH-1:1]};
    // Remainder stays below the divisor, so the shifted value needs WIDTH+1 bits
    // and a non-negative difference always has a clear top bit.
    div_shift = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opd_q};
    div_step  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], work_q[WIDTH-2:0], 1'b0}
                                : {div_diff[WIDTH-1:0],  work_q[WIDTH-2:0], 1'b1};
  end

  // Sign fix-up and accumulate applied to the finished magnitude result
  always_comb begin
    prod_s = neg_p_q ? -work_q : work_q;
    quot_s = neg_p_q ? -work_q[WIDTH-1:0] : work_q[WIDTH-1:0];
    rem_s  = neg_r_q ? -work_q[2*WIDTH-1:WIDTH] : work_q[2*WIDTH-1:WIDTH];
    case (op_q)
      OP_MULT: fix_res = prod_s;
      OP_DIV:  fix_res = {rem_s, quot_s};
      OP_MADD: fix_res = hilo_q + prod_s;
      default: fix_res = hilo_q - prod_s;
    endcase
  end

  // Next-state logic; annul returns to IDLE from anywhere
  always_comb begin
    state_d = state_q;
    if (annul_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (start_i) state_d = (fast_dbz || fast_zero) ? S_DONE : S_ITER;
        S_ITER: if (cnt_q == CW'(1)) state_d = S_FIX;
        S_FIX:  state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Datapath next values: capture on accept, iterate, then fix up
  always_comb begin
    cnt_d   = cnt_q;
    work_d  = work_q;
    opd_d   = opd_q;
    op_d    = op_q;
    neg_p_d = neg_p_q;
    neg_r_d = neg_r_q;
    hilo_d  = hilo_q;
    res_d   = res_q;
    dbz_d   = dbz_q;
    if (!annul_i) begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            cnt_d   = CW'(WIDTH);
            work_d  = {{WIDTH{1'b0}}, mag_a};
            opd_d   = mag_b;
            op_d    = op_i;
            neg_p_d = neg_a ^ neg_b;
            neg_r_d = neg_a;
            hilo_d  = hilo_i;
            dbz_d   = fast_dbz;
            // Only matters on the fast paths; the iterative path overwrites it in FIX.
            res_d   = fast_dbz ? {opa_i, {WIDTH{1'b1}}}
                               : ((op_i == OP_MULT) ? '0 : hilo_i);
          end
        end
        S_ITER: begin
          cnt_d  = cnt_q - CW'(1);
          work_d = (op_q == OP_DIV) ? div_step : mul_step;
        end
        S_FIX: res_d = fix_res;
        default: ;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      work_q  <= '0;
      opd_q   <= '0;
      op_q    <= '0;
      neg_p_q <= 1'b0;
      neg_r_q <= 1'b0;
      hilo_q  <= '0;
      res_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      opd_q   <= opd_d;
      op_q    <= op_d;
      neg_p_q <= neg_p_d;
      neg_r_q <= neg_r_d;
      hilo_q  <= hilo_d;
      res_q   <= res_d;
      dbz_q   <= dbz_d;
    end
  end

  // Outputs: stall request, and results presented only in DONE
  always_comb begin
    busy_o  = !annul_i && ((state_q == S_IDLE && start_i) ||
                           state_q == S_ITER || state_q == S_FIX);
    hi_o    = (state_q == S_DONE) ? res_q[2*WIDTH-1:WIDTH] : '0;
    lo_o    = (state_q == S_DONE) ? res_q[WIDTH-1:0] : '0;
    whilo_o = (state_q == S_DONE) && !annul_i;
    dbz_o   = (state_q == S_DONE) && !annul_i && dbz_q;
  end

endmodule
